wshb_mire_writer: RTL and testbench

//  Wishbone write master that fills the SDRAM frame buffer with a 16-pixel grid test pattern ("mire").

---
 rtl/video_pkg.sv | 20 ++
 rtl/mire_pattern.sv | 24 ++
 rtl/wshb_mire_writer.sv | 141 ++++++++++++++
 tb/tb_wshb_mire_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video timing defaults, grid constants and the writer FSM state type.
package video_pkg;

  localparam int          HDISP_DEF  = 800;
  localparam int          VDISP_DEF  = 480;
  localparam int          GRID_STEP  = 16;
  localparam logic [23:0] GRID_COLOR = 24'hFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  // Non-grid pixels carry their own coordinates so a dump is easy to read back.
  function automatic logic [23:0] plain_color(input logic [7:0] x8, input logic [7:0] y8);
    return {x8, y8, 8'h40};
  endfunction

endpackage

// File: rtl/mire_pattern.sv
// Combinational test-pattern generator: (x, y, shift) -> 24-bit RGB of the moving grid.
module mire_pattern
  import video_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [3:0]    s_i,
  output logic [23:0]   rgb_o
);

  logic [3:0] dx;
  logic       grid;

  // Grid step is 16, so "mod 16" is plain 4-bit truncation of the operands.
  always_comb begin
    dx    = 4'(x_i) - s_i;
    grid  = (dx == 4'd0) || (4'(y_i) == 4'd0);
    rgb_o = grid ? GRID_COLOR : plain_color(8'(x_i), 8'(y_i));
  end

endmodule

// File: rtl/wshb_mire_writer.sv
// Wishbone write master filling the frame buffer with the grid pattern, one word per pixel,
// releasing the bus for one cycle after every BURST acked writes.
module wshb_mire_writer
  import video_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  parameter int BURST = 64
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst,
  input  logic        enable,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);

  localparam logic [XW-1:0] X_LAST     = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(VDISP - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q;
  logic [BW-1:0] burst_q, burst_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          ack_ok;
  logic          last_pix;
  logic [23:0]   rgb_d;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    adr_d        = adr_q;
    burst_d      = burst_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    ack_ok       = (state_q == ST_WRITE) && wshb_ack;
    last_pix     = (x_q == X_LAST) && (y_q == Y_LAST);

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (ack_ok) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          // Frame end takes priority over a coinciding burst boundary.
          if (last_pix) begin
            adr_d        = '0;
            burst_d      = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            state_d      = enable ? ST_RELEASE : ST_IDLE;
          end else begin
            adr_d = adr_q + 32'd4;
            if (burst_q == BURST_LAST) begin
              burst_d = '0;
              state_d = ST_RELEASE;
            end else begin
              burst_d = burst_q + 1'b1;
            end
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_WRITE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pattern is evaluated on next-state coordinates and shift, so the data for the
  // first pixel of a new frame already uses the incremented frame count.
  mire_pattern #(
    .XW(XW),
    .YW(YW)
  ) u_pattern (
    .x_i  (x_d),
    .y_i  (y_d),
    .s_i  (frame_cnt_d[3:0]),
    .rgb_o(rgb_d)
  );

  always_ff @(posedge wshb_clk) begin
    if (wshb_rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      burst_q      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      adr_q        <= adr_d;
      dat_q        <= {8'h00, rgb_d};
      burst_q      <= burst_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wshb_cyc    = (state_q == ST_WRITE);
  assign wshb_stb    = (state_q == ST_WRITE);
  assign wshb_we     = (state_q == ST_WRITE);
  assign wshb_adr    = adr_q;
  assign wshb_dat_ms = dat_q;
  assign wshb_sel    = 4'b1111;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Directed bench for wshb_mire_writer: Wishbone memory slave, per-write address/data
// scoreboard, burst-gap checks, enable drop, mid-transfer reset and multi-frame shift.
module tb_wshb_mire_writer;

  localparam int HDISP = 32;
  localparam int VDISP = 4;
  localparam int BURST = 8;
  localparam int NPIX  = HDISP * VDISP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        ack = 1'b0;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  logic [31:0] mem  [0:NPIX-1];
  logic [31:0] img1 [0:NPIX-1];

  int ntests    = 0;
  int nfail     = 0;
  int widx      = 0;
  int tb_frames = 0;
  int fd_count  = 0;

  always #5 clk = ~clk;

  wshb_mire_writer #(
    .HDISP(HDISP),
    .VDISP(VDISP),
    .BURST(BURST)
  ) dut (
    .wshb_clk   (clk),
    .wshb_rst   (rst),
    .enable     (enable),
    .wshb_cyc   (cyc),
    .wshb_stb   (stb),
    .wshb_we    (we),
    .wshb_adr   (adr),
    .wshb_dat_ms(dat),
    .wshb_sel   (sel),
    .wshb_cti   (cti),
    .wshb_bte   (bte),
    .wshb_ack   (ack),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input int x, input int y, input int s);
    if ((((x - s) % 16) + 16) % 16 == 0 || (y % 16) == 0) return 32'h00FF_FFFF;
    return {8'h00, 8'(x), 8'(y), 8'h40};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    widx      = 0;
    tb_frames = 0;
    fd_count  = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  // Serve nwrites acked writes; maxdly>0 inserts random wait states before each ack.
  task automatic serve(input int nwrites, input int maxdly, input bit chk_gaps);
    int          got     = 0;
    int          cycles  = 0;
    int          wc      = 0;
    int          dly     = 0;
    int          low_len = 0;
    int          acks    = 0;
    bit          seen_hi = 1'b0;
    bit          pend    = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    dly = (maxdly > 0) ? int'($urandom_range(maxdly, 0)) : 0;
    while (got < nwrites) begin
      if (cycles > 4000) begin
        check("serve_timeout", got, nwrites);
        break;
      end
      ack = 1'b0;
      if (cyc && stb) begin
        if (pend) begin
          check("adr_hold", adr, pa);
          check("dat_hold", dat, pd);
        end
        if (chk_gaps && low_len > 0) check("gap_len", low_len, 1);
        low_len = 0;
        seen_hi = 1'b1;
        if (wc >= dly) begin
          ack = 1'b1;
          check("adr", adr, 32'(widx * 4));
          check("dat", dat, exp_pix(widx % HDISP, widx / HDISP, tb_frames % 16));
          mem[adr[8:2]] = dat;
          if (widx == NPIX - 1) tb_frames++;
          widx = (widx + 1) % NPIX;
          got++;
          acks++;
          pend = 1'b0;
          wc   = 0;
          dly  = (maxdly > 0) ? int'($urandom_range(maxdly, 0)) : 0;
        end else begin
          pend = 1'b1;
          pa   = adr;
          pd   = dat;
          wc++;
        end
      end else if (seen_hi) begin
        if (chk_gaps && low_len == 0) check("gap_pos", acks, BURST);
        low_len++;
        acks = 0;
      end
      tick();
      cycles++;
      if (frame_done === 1'b1) fd_count++;
    end
    ack = 1'b0;
  endtask

  initial begin
    // Reset state
    enable = 1'b0;
    do_reset();
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_adr", adr, 0);
    check("rst_dat", dat, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("const_sel", sel, 4'hF);
    check("const_cti", cti, 0);
    check("const_bte", bte, 0);
    tick();
    check("idle_cyc", cyc, 0);
    $display("[TB] step reset: checks done");

    // One frame, ack every cycle, burst gaps checked
    clear_mem();
    enable = 1'b1;
    serve(NPIX, 0, 1'b1);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_fd_count", fd_count, 1);
    check("t1_mem0", mem[0], 32'h00FF_FFFF);
    check("t1_mem1", mem[1], 32'h00FF_FFFF);
    check("t1_mem33", mem[33], 32'h0001_0140);
    check("t1_mem48", mem[48], 32'h00FF_FFFF);
    check("t1_mem127", mem[127], 32'h001F_0340);
    for (int i = 0; i < NPIX; i++) img1[i] = mem[i];
    $display("[TB] step frame1: frame_cnt=%0d frame_done pulses=%0d", frame_cnt, fd_count);

    // Random wait states, image must be identical
    do_reset();
    clear_mem();
    serve(NPIX, 5, 1'b0);
    for (int i = 0; i < NPIX; i++) check("t3_img", mem[i], img1[i]);
    $display("[TB] step random_ack: frame_cnt=%0d", frame_cnt);

    // Enable dropped mid-frame: frame completes, then bus stays idle
    do_reset();
    serve(50, 0, 1'b0);
    enable = 1'b0;
    serve(NPIX - 50, 0, 1'b0);
    check("t4_fd_count", fd_count, 1);
    check("t4_frame_done", frame_done, 1);
    check("t4_cyc_end", cyc, 0);
    check("t4_frame_cnt", frame_cnt, 1);
    tick();
    check("t4_fd_pulse", frame_done, 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_cyc_idle", cyc, 0);
      tick();
    end
    $display("[TB] step enable_drop: frame_cnt=%0d", frame_cnt);

    // Reset with a write pending
    enable = 1'b1;
    do_reset();
    serve(NPIX + 70, 0, 1'b0);
    check("t5_pending", cyc, 1);
    check("t5_frame_cnt_pre", frame_cnt, 1);
    rst = 1'b1;
    tick();
    check("t5_cyc", cyc, 0);
    check("t5_stb", stb, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    check("t5_adr", adr, 0);
    rst       = 1'b0;
    widx      = 0;
    tb_frames = 0;
    fd_count  = 0;
    tick();
    check("t5_restart_cyc", cyc, 1);
    check("t5_restart_adr", adr, 0);
    check("t5_restart_dat", dat, 32'h00FF_FFFF);
    serve(NPIX, 0, 1'b0);
    check("t5_frame_cnt_post", frame_cnt, 1);
    $display("[TB] step reset_mid: frame_cnt=%0d", frame_cnt);

    // 17 frames: grid shifts by frame_cnt[3:0], frame 17 repeats frame 1
    do_reset();
    clear_mem();
    serve(NPIX, 0, 1'b0);
    check("t6_f1_mem33", mem[33], 32'h0001_0140);
    clear_mem();
    serve(NPIX, 0, 1'b0);
    check("t6_f2_x1y1", mem[33], 32'h00FF_FFFF);
    check("t6_f2_x17y2", mem[81], 32'h00FF_FFFF);
    check("t6_f2_x16y1", mem[48], 32'h0010_0140);
    check("t6_f2_x0y1", mem[32], 32'h0000_0140);
    check("t6_f2_x1y3", mem[97], 32'h00FF_FFFF);
    $display("[TB] step frame2: frame_cnt=%0d", frame_cnt);
    for (int f = 3; f <= 17; f++) begin
      clear_mem();
      serve(NPIX, 0, 1'b0);
    end
    for (int i = 0; i < NPIX; i++) check("t6_f17_img", mem[i], img1[i]);
    check("t6_frame_cnt", frame_cnt, 17);
    check("t6_fd_count", fd_count, 17);
    $display("[TB] step frame17: frame_cnt=%0d frame_done pulses=%0d", frame_cnt, fd_count);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
